// File: rtl/uart_tx_gen2.sv
// uart_tx_gen2 - parametrised UART transmitter.
// A character FIFO feeds an oversampled serialiser. Frames carry a start bit,
// 5..DATA_W data bits (LSB first), optional parity, 1 / 1.5 / 2 stop bits and
// a programmable idle gap of whole bit times after the stop bits.
// Optional feature macro: UART_TX_CTS_FLOW_EN adds a cts_n input that gates
// the start of each new frame (frames already started always complete).
module uart_tx_gen2 #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 5,
    parameter int OVS        = 16
) (
    input  logic              clk,
    input  logic              wb_rst_n,
`ifdef UART_TX_CTS_FLOW_EN
    input  logic              cts_n,
`endif
    input  logic              enable,
    input  logic [3:0]        char_len,
    input  logic              par_en,
    input  logic              par_even,
    input  logic              par_stick,
    input  logic              stop2,
    input  logic              brk,
    input  logic [7:0]        gap,
    input  logic              tf_push,
    input  logic [DATA_W-1:0] tf_data,
    input  logic              tf_reset,
    output logic [CNT_W-1:0]  tf_count,
    output logic              tf_full,
    output logic              tf_overrun,
    output logic              tx_busy,
    output logic              tx_empty,
    output logic [2:0]        tstate,
    output logic              stx_pad_o
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    // Tick counter must reach 2*OVS-1 for a two-bit stop period.
    localparam int TICK_W = $clog2(2 * OVS) + 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5,
        ST_GAP    = 3'd6
    } tx_state_t;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // Out-of-range lengths are pulled into 5..DATA_W.
    function automatic logic [3:0] clamp_len(input logic [3:0] l);
        if (l < 4'd5) begin
            return 4'd5;
        end else if (l > 4'(DATA_W)) begin
            return 4'(DATA_W);
        end
        return l;
    endfunction

    // Mask keeping only the low l bits of a character.
    function automatic logic [DATA_W-1:0] len_mask(input logic [3:0] l);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i < int'(l)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    // Parity over an already-masked character; stick parity ignores the data.
    function automatic logic parity_bit(input logic [DATA_W-1:0] d,
                                        input logic              even,
                                        input logic              stick);
        if (stick) begin
            return ~even;
        end
        return even ? ^d : ~^d;
    endfunction

    // Stop period length in ticks, returned as terminal count (length - 1).
    function automatic logic [TICK_W-1:0] stop_last(input logic       s2,
                                                    input logic [3:0] l);
        if (!s2) begin
            return TICK_W'(OVS - 1);
        end else if (l == 4'd5) begin
            return TICK_W'((3 * OVS) / 2 - 1);
        end
        return TICK_W'(2 * OVS - 1);
    endfunction

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              overrun;
    logic              full;
    logic              tf_pop;
    logic              push_ok;

    tx_state_t         state;
    logic [TICK_W-1:0] tick_cnt;
    logic [7:0]        bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic [3:0]        len_l;
    logic              par_en_l;
    logic              par_bit_l;
    logic [TICK_W-1:0] stop_last_l;
    logic [7:0]        gap_l;
    logic              tick_last;
    logic              frame_bit;
    logic              stx;
    logic              cts_ok;

    logic [3:0]        load_len;
    logic [DATA_W-1:0] load_data;

    // ------------------------------------------------------------------
    // Clear-to-send qualification
    // ------------------------------------------------------------------
`ifdef UART_TX_CTS_FLOW_EN
    logic cts_s1;
    logic cts_s2;

    // Two-flop synchroniser for the asynchronous cts_n pin, idle = not clear.
    always_ff @(posedge clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            cts_s1 <= 1'b1;
            cts_s2 <= 1'b1;
        end else begin
            cts_s1 <= cts_n;
            cts_s2 <= cts_s1;
        end
    end

    assign cts_ok = ~cts_s2;
`else
    assign cts_ok = 1'b1;
`endif

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    // A pop only happens from LOAD on a tick and only when data is present
    // (a flush between IDLE and LOAD can leave LOAD with an empty FIFO).
    assign tf_pop  = enable && (state == ST_LOAD) && (count != '0);
    // Full FIFO still accepts a write when the head leaves in the same clk.
    assign push_ok = tf_push && (!full || tf_pop);

    // Storage array; a flush wins over a same-cycle write.
    always_ff @(posedge clk) begin
        if (push_ok && !tf_reset) begin
            mem[wr_ptr] <= tf_data;
        end
    end

    // Pointers, occupancy and the sticky overrun flag.
    always_ff @(posedge clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else if (tf_reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (tf_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_ok && !tf_pop) begin
                count <= count + CNT_W'(1);
            end else if (tf_pop && !push_ok) begin
                count <= count - CNT_W'(1);
            end
            if (tf_push && full && !tf_pop) begin
                overrun <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Serialiser
    // ------------------------------------------------------------------
    assign load_len  = clamp_len(char_len);
    assign load_data = mem[rd_ptr] & len_mask(load_len);
    assign tick_last = (tick_cnt == TICK_W'(OVS - 1));

    // Frame state machine; all movement is gated by the oversample tick.
    always_ff @(posedge clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state       <= ST_IDLE;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            len_l       <= 4'd5;
            par_en_l    <= 1'b0;
            par_bit_l   <= 1'b0;
            stop_last_l <= TICK_W'(OVS - 1);
            gap_l       <= '0;
        end else if (enable) begin
            case (state)
                ST_IDLE: begin
                    tick_cnt <= '0;
                    bit_cnt  <= '0;
                    if ((count != '0) && cts_ok) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    tick_cnt <= '0;
                    bit_cnt  <= '0;
                    if (count != '0) begin
                        // Snapshot everything the frame needs so later
                        // register writes cannot disturb it.
                        shreg       <= load_data;
                        len_l       <= load_len;
                        par_en_l    <= par_en;
                        par_bit_l   <= parity_bit(load_data, par_even, par_stick);
                        stop_last_l <= stop_last(stop2, load_len);
                        gap_l       <= gap;
                        state       <= ST_START;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_START: begin
                    if (tick_last) begin
                        tick_cnt <= '0;
                        state    <= ST_DATA;
                    end else begin
                        tick_cnt <= tick_cnt + TICK_W'(1);
                    end
                end
                ST_DATA: begin
                    if (tick_last) begin
                        tick_cnt <= '0;
                        shreg    <= shreg >> 1;
                        if (bit_cnt == ({4'b0000, len_l} - 8'd1)) begin
                            bit_cnt <= '0;
                            state   <= par_en_l ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 8'd1;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + TICK_W'(1);
                    end
                end
                ST_PARITY: begin
                    if (tick_last) begin
                        tick_cnt <= '0;
                        state    <= ST_STOP;
                    end else begin
                        tick_cnt <= tick_cnt + TICK_W'(1);
                    end
                end
                ST_STOP: begin
                    if (tick_cnt == stop_last_l) begin
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= (gap_l != 8'd0) ? ST_GAP : ST_IDLE;
                    end else begin
                        tick_cnt <= tick_cnt + TICK_W'(1);
                    end
                end
                ST_GAP: begin
                    // bit_cnt counts whole idle bit times here.
                    if (tick_last) begin
                        tick_cnt <= '0;
                        if (bit_cnt == (gap_l - 8'd1)) begin
                            bit_cnt <= '0;
                            state   <= ST_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 8'd1;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + TICK_W'(1);
                    end
                end
                default: begin
                    tick_cnt <= '0;
                    bit_cnt  <= '0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

    // Line level implied by the current state.
    always_comb begin
        frame_bit = 1'b1;
        case (state)
            ST_START:  frame_bit = 1'b0;
            ST_DATA:   frame_bit = shreg[0];
            ST_PARITY: frame_bit = par_bit_l;
            default:   frame_bit = 1'b1;
        endcase
    end

    // Registered pad driver; break overrides the line without stalling the FSM.
    always_ff @(posedge clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            stx <= 1'b1;
        end else begin
            stx <= brk ? 1'b0 : frame_bit;
        end
    end

    assign stx_pad_o  = stx;
    assign tstate     = state;
    assign tf_count   = count;
    assign tf_full    = full;
    assign tf_overrun = overrun;
    assign tx_busy    = (state != ST_IDLE);
    assign tx_empty   = (count == '0) && (state == ST_IDLE);

endmodule

// File: tb/tb_uart_tx_gen2.sv
// tb_uart_tx_gen2 - directed self-checking bench for uart_tx_gen2.
// The oversample tick is pulsed every second clk, so one bit time is
// 2*OVS clk samples on the logged stx waveform.
module tb_uart_tx_gen2;

    localparam int OVS = 16;
    localparam int BIT = 2 * OVS;

    logic       clk = 1'b0;
    logic       wb_rst_n;
    logic       enable;
    logic [3:0] char_len;
    logic       par_en;
    logic       par_even;
    logic       par_stick;
    logic       stop2;
    logic       brk;
    logic [7:0] gap;
    logic       tf_push;
    logic [7:0] tf_data;
    logic       tf_reset;
    logic [4:0] tf_count;
    logic       tf_full;
    logic       tf_overrun;
    logic       tx_busy;
    logic       tx_empty;
    logic [2:0] tstate;
    logic       stx_pad_o;
`ifdef UART_TX_CTS_FLOW_EN
    logic       cts_n;
`endif

    int   n_checks = 0;
    int   n_err    = 0;
    logic logging  = 1'b0;
    logic en_run   = 1'b0;
    int   push_idx = 0;

    logic       stx_log[$];
    logic [2:0] st_log[$];
    logic       en_log[$];

    uart_tx_gen2 #(
        .DATA_W(8), .FIFO_DEPTH(16), .CNT_W(5), .OVS(OVS)
    ) dut (
        .clk       (clk),
        .wb_rst_n  (wb_rst_n),
`ifdef UART_TX_CTS_FLOW_EN
        .cts_n     (cts_n),
`endif
        .enable    (enable),
        .char_len  (char_len),
        .par_en    (par_en),
        .par_even  (par_even),
        .par_stick (par_stick),
        .stop2     (stop2),
        .brk       (brk),
        .gap       (gap),
        .tf_push   (tf_push),
        .tf_data   (tf_data),
        .tf_reset  (tf_reset),
        .tf_count  (tf_count),
        .tf_full   (tf_full),
        .tf_overrun(tf_overrun),
        .tx_busy   (tx_busy),
        .tx_empty  (tx_empty),
        .tstate    (tstate),
        .stx_pad_o (stx_pad_o)
    );

    always #5 clk = ~clk;

    // One-clk-wide tick on every other clk while en_run is set.
    initial begin
        enable = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            enable = en_run ? ~enable : 1'b0;
        end
    end

    // Waveform log: sample i holds the outputs after posedge i.
    always @(negedge clk) begin
        if (logging) begin
            stx_log.push_back(stx_pad_o);
            st_log.push_back(tstate);
            en_log.push_back(enable);
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_char(input logic [7:0] d);
        tf_data = d;
        tf_push = 1'b1;
        @(posedge clk);
        push_idx = stx_log.size();
        #1;
        tf_push = 1'b0;
    endtask

    task automatic log_start();
        stx_log.delete();
        st_log.delete();
        en_log.delete();
        logging = 1'b1;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n;
        n = 0;
        while (!(tx_empty && tstate == 3'd0) && n < max) begin
            step(1);
            n++;
        end
        chk({tag, "_idle_reached"}, (n < max), 1);
    endtask

    task automatic wait_state(input string tag, input logic [2:0] st, input int max);
        int n;
        n = 0;
        while (tstate !== st && n < max) begin
            step(1);
            n++;
        end
        chk({tag, "_state_reached"}, (n < max), 1);
    endtask

    function automatic int find_low(input int from);
        for (int i = from; i < stx_log.size(); i++) begin
            if (stx_log[i] == 1'b0) return i;
        end
        return -1;
    endfunction

    // Expected first low sample: clk after the 2nd tick at or after edge 'from'.
    function automatic int expect_start(input int from);
        int e1;
        int e2;
        e1 = -1;
        e2 = -1;
        for (int i = (from < 1) ? 1 : from; i <= en_log.size() && e2 < 0; i++) begin
            if (en_log[i-1]) begin
                if (e1 < 0) e1 = i;
                else        e2 = i;
            end
        end
        return (e2 < 0) ? -1 : e2 + 1;
    endfunction

    function automatic int run_len(input logic [2:0] v, input int from);
        int i;
        int n;
        i = (from < 0) ? 0 : from;
        n = 0;
        while (i < st_log.size() && st_log[i] != v) i++;
        while (i < st_log.size() && st_log[i] == v) begin
            n++;
            i++;
        end
        return n;
    endfunction

    // Compare one frame sample-by-sample plus decoded data and parity.
    task automatic check_frame(input string tag, input int s, input int len,
                               input logic [7:0] d, input logic par_on, input logic par_v);
        int         nb;
        int         mism;
        int         idx;
        logic       exp_b;
        logic [7:0] obs;
        logic [7:0] msk;
        chk({tag, "_found"}, (s >= 0), 1);
        if (s < 0) return;
        nb   = 1 + len + (par_on ? 1 : 0);
        mism = 0;
        for (int k = 0; k <= nb; k++) begin
            if (k == 0)                      exp_b = 1'b0;
            else if (k <= len)               exp_b = d[k-1];
            else if (k == len + 1 && par_on) exp_b = par_v;
            else                             exp_b = 1'b1;
            for (int j = 0; j < BIT; j++) begin
                idx = s + k * BIT + j;
                if (idx >= stx_log.size() || stx_log[idx] !== exp_b) mism++;
            end
        end
        chk({tag, "_wave"}, mism, 0);
        obs = '0;
        msk = '0;
        for (int k = 0; k < len; k++) begin
            msk[k] = 1'b1;
            idx = s + (k + 1) * BIT + BIT / 2;
            obs[k] = (idx < stx_log.size()) ? stx_log[idx] : 1'bx;
        end
        chk({tag, "_data"}, obs, d & msk);
        if (par_on) begin
            idx = s + (len + 1) * BIT + BIT / 2;
            chk({tag, "_par"}, (idx < stx_log.size()) ? stx_log[idx] : 1'bx, par_v);
        end
    endtask

    initial begin
        int s;
        int s2;
        int p1;
        int c;

        wb_rst_n  = 1'b0;
        char_len  = 4'd8;
        par_en    = 1'b0;
        par_even  = 1'b0;
        par_stick = 1'b0;
        stop2     = 1'b0;
        brk       = 1'b0;
        gap       = 8'd0;
        tf_push   = 1'b0;
        tf_data   = 8'd0;
        tf_reset  = 1'b0;
`ifdef UART_TX_CTS_FLOW_EN
        cts_n     = 1'b0;
`endif
        step(3);
        chk("rst_stx", stx_pad_o, 1);
        chk("rst_tstate", tstate, 0);
        chk("rst_count", tf_count, 0);
        chk("rst_full", tf_full, 0);
        chk("rst_overrun", tf_overrun, 0);
        chk("rst_busy", tx_busy, 0);
        chk("rst_empty", tx_empty, 1);
        wb_rst_n = 1'b1;
        en_run   = 1'b1;
        step(4);

        // 0xA5, 8N1: latency, bits 1,0,1,0,0,1,0,1, one stop bit.
        log_start();
        push_char(8'hA5);
        wait_idle("a5", 2000);
        step(8);
        logging = 1'b0;
        s = find_low(push_idx);
        chk("a5_latency", s, expect_start(push_idx + 1));
        check_frame("a5", s, 8, 8'hA5, 1'b0, 1'b0);
        chk("a5_stop_len", run_len(3'd5, s), 2 * 16);
        chk("a5_empty", tx_empty, 1);
        chk("a5_busy", tx_busy, 0);

        // 7 bits even parity, 0x53 has four ones -> parity 0.
        char_len = 4'd7;
        par_en   = 1'b1;
        par_even = 1'b1;
        log_start();
        push_char(8'h53);
        wait_idle("p_even", 2000);
        step(8);
        logging = 1'b0;
        check_frame("p_even", find_low(push_idx), 7, 8'h53, 1'b1, 1'b0);

        // Stick parity with par_even=0 -> parity bit 1.
        par_stick = 1'b1;
        par_even  = 1'b0;
        log_start();
        push_char(8'h53);
        wait_idle("p_stick", 2000);
        step(8);
        logging = 1'b0;
        check_frame("p_stick", find_low(push_idx), 7, 8'h53, 1'b1, 1'b1);
        par_en    = 1'b0;
        par_stick = 1'b0;

        // stop2: 1.5 stop bits at 5-bit length, 2 stop bits at 8-bit length.
        char_len = 4'd5;
        stop2    = 1'b1;
        log_start();
        push_char(8'h0A);
        wait_idle("s15", 2000);
        step(8);
        logging = 1'b0;
        s = find_low(push_idx);
        check_frame("s15", s, 5, 8'h0A, 1'b0, 1'b0);
        chk("s15_stop_len", run_len(3'd5, s), 2 * 24);
        char_len = 4'd8;
        log_start();
        push_char(8'h0A);
        wait_idle("s2", 2000);
        step(8);
        logging = 1'b0;
        chk("s2_stop_len", run_len(3'd5, find_low(push_idx)), 2 * 32);
        stop2 = 1'b0;

        // Fill with ticks stopped: full at 16, 17th push overruns.
        en_run = 1'b0;
        step(3);
        for (int i = 0; i < 16; i++) push_char(8'(i));
        chk("fill_count", tf_count, 16);
        chk("fill_full", tf_full, 1);
        chk("fill_overrun", tf_overrun, 0);
        push_char(8'hEE);
        chk("ovr_count", tf_count, 16);
        chk("ovr_flag", tf_overrun, 1);
        tf_reset = 1'b1;
        step(1);
        tf_reset = 1'b0;
        chk("flush_count", tf_count, 0);
        chk("flush_overrun", tf_overrun, 0);
        chk("flush_full", tf_full, 0);
        push_char(8'h11);
        tf_reset = 1'b1;
        tf_push  = 1'b1;
        step(1);
        tf_reset = 1'b0;
        tf_push  = 1'b0;
        chk("flush_vs_push_count", tf_count, 0);
        chk("flush_vs_push_empty", tx_empty, 1);

        // Flush while a frame is on the wire: frame completes, queue is gone.
        en_run = 1'b1;
        step(2);
        log_start();
        push_char(8'h3C);
        p1 = push_idx;
        wait_state("inflight", 3'd3, 200);
        push_char(8'h81);
        push_char(8'h82);
        tf_reset = 1'b1;
        step(1);
        tf_reset = 1'b0;
        chk("inflight_count", tf_count, 0);
        wait_idle("inflight", 2000);
        step(40);
        logging = 1'b0;
        s = find_low(p1);
        check_frame("inflight", s, 8, 8'h3C, 1'b0, 1'b0);
        chk("inflight_no_more", find_low(s + 10 * BIT), -1);

        // gap=3: 16 stop + 48 gap + 2 idle/load ticks between frames.
        gap = 8'd3;
        log_start();
        push_char(8'h55);
        p1 = push_idx;
        push_char(8'h55);
        wait_idle("gap", 4000);
        step(8);
        logging = 1'b0;
        s = find_low(p1);
        check_frame("gap1", s, 8, 8'h55, 1'b0, 1'b0);
        s2 = find_low(s + 9 * BIT);
        chk("gap_high_run", s2 - (s + 9 * BIT), 2 * (16 + 48 + 2));
        check_frame("gap2", s2, 8, 8'h55, 1'b0, 1'b0);
        chk("gap_state_len", run_len(3'd6, s), 2 * 48);
        gap = 8'd0;

        // Break forces the line low while the FSM keeps moving.
        push_char(8'hFF);
        wait_state("brk", 3'd3, 200);
        brk = 1'b1;
        step(1);
        chk("brk_data_low", stx_pad_o, 0);
        wait_state("brk_adv", 3'd5, 1000);
        step(1);
        chk("brk_stop_low", stx_pad_o, 0);
        chk("brk_tstate", tstate, 5);
        brk = 1'b0;
        step(1);
        chk("brk_release", stx_pad_o, 1);
        wait_idle("brk", 2000);

        // Asynchronous reset in the middle of a frame.
        push_char(8'h00);
        wait_state("arst", 3'd3, 200);
        step(2);
        chk("arst_pre_low", stx_pad_o, 0);
        #3;
        wb_rst_n = 1'b0;
        #1;
        chk("arst_stx", stx_pad_o, 1);
        chk("arst_tstate", tstate, 0);
        chk("arst_busy", tx_busy, 0);
        @(posedge clk);
        #1;
        wb_rst_n = 1'b1;
        step(2);
        chk("arst_count", tf_count, 0);

`ifdef UART_TX_CTS_FLOW_EN
        // Not clear to send: data waits in the FIFO.
        cts_n = 1'b1;
        step(6);
        log_start();
        push_char(8'h5A);
        step(60);
        chk("cts_hold_state", tstate, 0);
        chk("cts_hold_count", tf_count, 1);
        c = stx_log.size();
        cts_n = 1'b0;
        wait_state("cts", 3'd3, 200);
        cts_n = 1'b1;
        wait_idle("cts", 2000);
        step(8);
        logging = 1'b0;
        s = find_low(c);
        chk("cts_latency", s, expect_start(c + 3));
        check_frame("cts", s, 8, 8'h5A, 1'b0, 1'b0);
        cts_n = 1'b0;
`else
        c = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
